// File: rtl/mult_acc_pkg.sv
// Shared constants and FSM state encoding for the sequential multiply-accumulate datapath.
package mult_acc_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_ACC_WIDTH = 2 * DEF_WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_core.sv
// Shift-add multiplier core: one multiplier bit per step, partial product kept at full 2*WIDTH.
module shift_add_core
    import mult_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   partial,
    output logic                 last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend = '0;
        if (b_reg[0]) begin
            addend = {{WIDTH{1'b0}}, a_reg} << cnt;
        end
    end

    assign last = step && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            partial <= '0;
        end else if (load) begin
            a_reg   <= a;
            b_reg   <= b;
            cnt     <= '0;
            partial <= '0;
        end else if (step) begin
            partial <= partial + addend;
            b_reg   <= b_reg >> 1;
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mult_acc.sv
// Sequential unsigned multiplier with load/add accumulator, sticky overflow and start/done handshake.
module seq_mult_acc
    import mult_acc_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   acc_mode,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   ovf
);

    state_t state, state_next;

    logic                 busy_next;
    logic                 done_next;
    logic                 load;
    logic                 step;
    logic                 last;
    logic                 mode_reg;
    logic [2*WIDTH-1:0]   partial;
    logic [ACC_WIDTH-1:0] partial_ext;
    logic [ACC_WIDTH-1:0] acc_base;
    logic                 ovf_base;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_next;

    // A new start is accepted whenever no product is being formed, including the FIN cycle.
    assign load = start && (state != RUN);
    assign step = (state == RUN);

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .a       (a),
        .b       (b),
        .partial (partial),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = FIN;
            FIN:     state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == RUN);
        done_next = (state_next == FIN);
    end

    // clr is folded in ahead of the FIN write so a same-cycle clear leaves only the new result.
    always_comb begin
        partial_ext = {{(ACC_WIDTH - 2*WIDTH){1'b0}}, partial};
        acc_base    = clr ? '0 : acc_out;
        ovf_base    = clr ? 1'b0 : ovf;
        sum         = {1'b0, acc_base} + {1'b0, partial_ext};
        acc_next    = acc_base;
        ovf_next    = ovf_base;
        if (state == FIN) begin
            if (mode_reg) begin
                acc_next = sum[ACC_WIDTH-1:0];
                ovf_next = ovf_base | sum[ACC_WIDTH];
            end else begin
                acc_next = partial_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= 1'b0;
            product  <= '0;
            acc_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (load) begin
                mode_reg <= acc_mode;
            end
            if (state == FIN) begin
                product <= partial;
            end
            acc_out <= acc_next;
            ovf     <= ovf_next;
        end
    end

endmodule

// File: tb/tb_seq_mult_acc.sv
// Directed and randomized checks of seq_mult_acc against a transaction-level arithmetic model.
module tb_seq_mult_acc;

    localparam int W  = 8;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          acc_mode;
    logic          clr;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;
    logic [AW-1:0] acc_out;
    logic          ovf;

    seq_mult_acc #(
        .WIDTH     (W),
        .ACC_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .acc_mode (acc_mode),
        .clr      (clr),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .acc_out  (acc_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;
    int t0     = 0;

    longint m_acc  = 0;
    longint m_prod = 0;
    bit     m_ovf  = 0;
    int     p_a    = 0;
    int     p_b    = 0;
    bit     p_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input int a_i, input int b_i, input bit mode_i);
        a        = W'(a_i);
        b        = W'(b_i);
        acc_mode = mode_i;
        start    = 1'b1;
        p_a      = a_i;
        p_b      = b_i;
        p_mode   = mode_i;
        t0       = cyc;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && done !== 1'b1; i++) begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            step();
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_fin"}, 64'(busy), 64'd0);
        check({tag, " latency"}, 64'(cyc - t0), 64'd9);
    endtask

    task automatic model_fin(input bit clr_fin);
        longint s;
        if (clr_fin) begin
            m_acc = 0;
            m_ovf = 0;
        end
        m_prod = longint'(p_a) * longint'(p_b);
        if (p_mode) begin
            s = m_acc + m_prod;
            if (s >= (64'd1 << AW)) m_ovf = 1;
            m_acc = s % (64'd1 << AW);
        end else begin
            m_acc = m_prod;
        end
    endtask

    task automatic complete(input string tag, input bit clr_fin, input bit bb,
                            input int a_n, input int b_n, input bit mode_n);
        model_fin(clr_fin);
        clr = clr_fin;
        if (bb) begin
            a        = W'(a_n);
            b        = W'(b_n);
            acc_mode = mode_n;
            start    = 1'b1;
            p_a      = a_n;
            p_b      = b_n;
            p_mode   = mode_n;
            t0       = cyc;
        end
        step();
        clr   = 1'b0;
        start = 1'b0;
        check({tag, " done_off"}, 64'(done), 64'd0);
        check({tag, " product"}, 64'(product), 64'(m_prod));
        check({tag, " acc_out"}, 64'(acc_out), 64'(m_acc));
        check({tag, " ovf"}, 64'(ovf), 64'(m_ovf));
        if (bb) check({tag, " b2b_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic op(input string tag, input int a_i, input int b_i, input bit mode_i,
                      input bit clr_fin);
        launch(a_i, b_i, mode_i);
        wait_done(tag);
        complete(tag, clr_fin, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; acc_mode = 1'b0; clr = 1'b0; a = '0; b = '0;
        step();
        step();
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst product", 64'(product), 64'd0);
        check("rst acc", 64'(acc_out), 64'd0);
        check("rst ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: load 0xFF*0xFF
        op("t1", 8'hFF, 8'hFF, 1'b0, 1'b0);
        check("t1 const", 64'(acc_out), 64'h0FE01);

        // 2: accumulate 200*200 twice
        op("t2 load", 200, 200, 1'b0, 1'b0);
        op("t2 add", 200, 200, 1'b1, 1'b0);
        check("t2 const", 64'(acc_out), 64'h13880);

        // 3: overflow, sticky through a load, cleared by clr
        op("t3 load", 8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) op("t3 add", 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("t3 acc const", 64'(acc_out), 64'h0DE11);
        check("t3 ovf const", 64'(ovf), 64'd1);
        op("t3 reload", 8'h12, 8'h34, 1'b0, 1'b0);
        check("t3 ovf sticky", 64'(ovf), 64'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        m_acc = 0;
        m_ovf = 0;
        check("t3 clr acc", 64'(acc_out), 64'd0);
        check("t3 clr ovf", 64'(ovf), 64'd0);

        // 4: zero operand, ignored start mid-run, back-to-back start in FIN
        launch(0, 8'hAB, 1'b0);
        step();
        step();
        step();
        a = 8'h01; b = 8'h01; acc_mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t4 zero");
        complete("t4 zero", 1'b0, 1'b1, 3, 7, 1'b1);
        wait_done("t4 b2b");
        complete("t4 b2b", 1'b0, 1'b0, 0, 0, 1'b0);

        // 5: clr in the FIN cycle of an add
        op("t5 load", 10, 10, 1'b0, 1'b0);
        op("t5 add", 3, 5, 1'b1, 1'b1);
        check("t5 const", 64'(acc_out), 64'd15);

        // 6: asynchronous reset mid-run, then a clean operation
        launch(8'h37, 8'h59, 1'b0);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t6 busy", 64'(busy), 64'd0);
        check("t6 done", 64'(done), 64'd0);
        check("t6 product", 64'(product), 64'd0);
        check("t6 acc", 64'(acc_out), 64'd0);
        check("t6 ovf", 64'(ovf), 64'd0);
        m_acc = 0; m_prod = 0; m_ovf = 0;
        step();
        rst_n = 1'b1;
        step();
        op("t6 after", 8'hC3, 8'h5A, 1'b1, 1'b0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            op("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
